// File: rtl/proc_frame_ctrl.sv
// proc_frame_ctrl: register-programmed frame sequencer for the pixel processor.
// Clears the processor, gates one frame of input pixels and tracks output drain.
module proc_frame_ctrl #(
    parameter int FRAME_PIXELS = 4096,
    parameter int WARMUP       = 2051,
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_TO     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        proc_valid,
    input  logic        proc_ready,
    input  logic        proc_vout,
    input  logic        sink_ready,
    output logic        proc_clr,
    output logic [1:0]  cfg_mode,
    output logic [71:0] cfg_kernel,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [20:0] CNT_MAX    = '1;
    localparam logic [20:0] EXP_PASS   = 21'(FRAME_PIXELS);
    localparam logic [20:0] EXP_CONV   =
        (FRAME_PIXELS > WARMUP) ? 21'(FRAME_PIXELS - WARMUP) : 21'd0;
    localparam logic [20:0] FRAME_LAST = 21'(FRAME_PIXELS - 1);
    localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TO - 1);

    state_t      state, state_nxt;
    logic [15:0] clr_cnt;
    logic [15:0] drain_idle;
    logic [20:0] in_cnt;
    logic [20:0] out_cnt;
    logic [20:0] exp_cnt;
    logic        done, err, irq_en, abort_q;
    logic        ctrl_wr, stat_wr, do_start, do_abort;
    logic        gate_open, in_acc, out_hs;
    logic        drain_tmo, overrun;
    logic [31:0] rd_mux;

    assign busy      = (state != S_IDLE);
    assign ctrl_wr   = reg_wr && (reg_addr == 3'd0);
    assign stat_wr   = reg_wr && (reg_addr == 3'd5);
    assign do_abort  = ctrl_wr && reg_wdata[1] && busy;
    assign do_start  = ctrl_wr && reg_wdata[0] && !reg_wdata[1] && !busy;

    // Gates close in the abort cycle so no pixel slips past a cancelled frame.
    assign gate_open  = (state == S_STREAM) && !do_abort;
    assign proc_valid = gate_open && src_valid;
    assign src_ready  = gate_open && proc_ready;
    assign in_acc     = gate_open && src_valid && proc_ready;
    assign out_hs     = busy && proc_vout && sink_ready;

    assign exp_cnt  = (cfg_mode == 2'b10) ? EXP_CONV : EXP_PASS;
    assign proc_clr = (state == S_CLEAR) || abort_q;
    assign irq      = done && irq_en;

    always_comb begin
        state_nxt = state;
        drain_tmo = 1'b0;
        overrun   = 1'b0;
        if (do_abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (do_start) state_nxt = S_CLEAR;
                S_CLEAR:  if (clr_cnt == CLR_LAST) state_nxt = S_STREAM;
                S_STREAM: if (in_acc && in_cnt == FRAME_LAST) state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (out_cnt > exp_cnt) begin
                        overrun   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (out_cnt == exp_cnt) begin
                        state_nxt = S_DONE;
                    end else if (!out_hs && drain_idle == DRAIN_LAST) begin
                        drain_tmo = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            clr_cnt    <= '0;
            drain_idle <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            abort_q <= do_abort;
            clr_cnt <= (state == S_CLEAR) ? clr_cnt + 16'd1 : 16'd0;
            if (state == S_DRAIN && !out_hs) drain_idle <= drain_idle + 16'd1;
            else drain_idle <= '0;

            if (do_start) in_cnt <= '0;
            else if (in_acc && in_cnt != CNT_MAX) in_cnt <= in_cnt + 21'd1;

            if (do_start) out_cnt <= '0;
            else if (out_hs && out_cnt != CNT_MAX) out_cnt <= out_cnt + 21'd1;

            // Hardware set events take priority over a software W1C.
            if (do_start) done <= 1'b0;
            else if (state == S_DONE) done <= 1'b1;
            else if (stat_wr && reg_wdata[1]) done <= 1'b0;

            if (do_start) err <= 1'b0;
            else if (do_abort || drain_tmo || overrun) err <= 1'b1;
            else if (stat_wr && reg_wdata[2]) err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en     <= 1'b0;
            cfg_mode   <= '0;
            cfg_kernel <= '0;
        end else begin
            if (ctrl_wr) irq_en <= reg_wdata[2];
            if (reg_wr && !busy) begin
                unique case (1'b1)
                    reg_addr == 3'd1: cfg_mode          <= reg_wdata[1:0];
                    reg_addr == 3'd2: cfg_kernel[31:0]  <= reg_wdata;
                    reg_addr == 3'd3: cfg_kernel[63:32] <= reg_wdata;
                    reg_addr == 3'd4: cfg_kernel[71:64] <= reg_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            3'd0: rd_mux = {29'd0, irq_en, 2'b00};
            3'd1: rd_mux = {30'd0, cfg_mode};
            3'd2: rd_mux = cfg_kernel[31:0];
            3'd3: rd_mux = cfg_kernel[63:32];
            3'd4: rd_mux = {24'd0, cfg_kernel[71:64]};
            3'd5: rd_mux = {26'd0, state, err, done, busy};
            3'd6: rd_mux = {11'd0, in_cnt};
            3'd7: rd_mux = {11'd0, out_cnt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_rdata <= '0;
        else if (reg_rd) reg_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_proc_frame_ctrl.sv
// tb_proc_frame_ctrl: randomized frame runs against a transaction-level model
// of the sequencer and a simple 1:1 / warm-up processor stand-in.
module tb_proc_frame_ctrl;
    localparam int FP  = 16;
    localparam int WU  = 10;
    localparam int CLR = 4;
    localparam int DTO = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr, reg_rd;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        src_valid, src_ready, proc_valid, proc_ready;
    logic        proc_vout, sink_ready, proc_clr, busy, irq;
    logic [1:0]  cfg_mode;
    logic [71:0] cfg_kernel;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [1:0] model_mode = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    proc_frame_ctrl #(
        .FRAME_PIXELS(FP), .WARMUP(WU), .CLR_CYCLES(CLR), .DRAIN_TO(DTO)
    ) dut (
        .clk(clk), .rst(rst),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .src_valid(src_valid), .src_ready(src_ready),
        .proc_valid(proc_valid), .proc_ready(proc_ready),
        .proc_vout(proc_vout), .sink_ready(sink_ready),
        .proc_clr(proc_clr), .cfg_mode(cfg_mode), .cfg_kernel(cfg_kernel),
        .busy(busy), .irq(irq)
    );

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_wr = 1'b0;
        if (a == 3'd0 && d[0]) start_cyc = cyc;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_rd = 1'b1; reg_addr = a;
        @(posedge clk); #1;
        reg_rd = 1'b0;
        d = reg_rdata;
    endtask

    // Runs the frame already started; the model decides when gates must be open.
    task automatic run_frame(input int bp, input bit withhold, input int stop_at,
                             output int acc, output int outs, output int gerr,
                             output int dcyc, output bit tmo);
        int owed, k;
        logic hs_in, hs_out, open;
        acc = 0; outs = 0; gerr = 0; dcyc = 0; tmo = 1'b1; owed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (bp == 0) begin
                src_valid = 1'b1; proc_ready = 1'b1;
            end else begin
                src_valid = 1'($urandom_range(0, 1));
                proc_ready = ~proc_ready;
            end
            proc_vout = (owed > 0) && !withhold;
            sink_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k = cyc - start_cyc;
            open = (k >= CLR) && (acc < FP);
            if (proc_valid !== (open && src_valid)) gerr++;
            if (src_ready !== (open && proc_ready)) gerr++;
            if (proc_clr !== (k < CLR)) gerr++;
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
            if (acc == FP) dcyc++;
            hs_in = proc_valid && proc_ready;
            hs_out = proc_vout && sink_ready;
            @(posedge clk); #1;
            if (hs_out) begin
                owed--; outs++;
            end
            if (hs_in) begin
                acc++;
                if (model_mode != 2'b10 || acc > WU) owed++;
            end
            if (stop_at > 0 && acc == stop_at) begin
                tmo = 1'b0;
                break;
            end
        end
        proc_vout = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tests_run++;
        if ({busy, irq, proc_clr, src_ready, proc_valid, cfg_mode, cfg_kernel} !== '0
            || reg_rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b irq=%b clr=%b mode=%h kern=%h rdata=%h, want all 0",
                     busy, irq, proc_clr, cfg_mode, cfg_kernel, reg_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rd(3'd5, d);
        tests_run++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL reset_status: got %h want 0", d);
        end
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL reset_in_cnt: got %h want 0", d);
        end
    endtask

    task automatic test_basic();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        wr(3'd1, 32'd0); model_mode = 2'b00;
        wr(3'd0, 32'd1);
        run_frame(0, 1'b0, 0, acc, outs, gerr, dcyc, tmo);
        tests_run++;
        if (tmo || acc != FP || outs != FP || gerr != 0) begin
            fails++;
            $display("FAIL basic_frame: tmo=%0d acc=%0d outs=%0d gate_err=%0d, want 0/%0d/%0d/0",
                     tmo, acc, outs, gerr, FP, FP);
        end
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'(FP)) begin
            fails++; $display("FAIL basic_in_cnt: got %0d want %0d", d, FP);
        end
        rd(3'd7, d);
        tests_run++;
        if (d !== 32'(FP)) begin
            fails++; $display("FAIL basic_out_cnt: got %0d want %0d", d, FP);
        end
        rd(3'd5, d);
        tests_run++;
        if (d !== 32'h2) begin
            fails++; $display("FAIL basic_status: got %h want 2", d);
        end
    endtask

    task automatic test_conv();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        wr(3'd1, 32'd2); model_mode = 2'b10;
        wr(3'd0, 32'd1);
        run_frame(0, 1'b0, 0, acc, outs, gerr, dcyc, tmo);
        rd(3'd5, d);
        tests_run++;
        if (tmo || outs != FP - WU || gerr != 0 || d !== 32'h2) begin
            fails++;
            $display("FAIL conv_frame: tmo=%0d outs=%0d gate_err=%0d status=%h, want 0/%0d/0/2",
                     tmo, outs, gerr, d, FP - WU);
        end
        wr(3'd0, 32'd1);
        run_frame(0, 1'b1, 0, acc, outs, gerr, dcyc, tmo);
        rd(3'd5, d);
        tests_run++;
        if (tmo || d !== 32'h6) begin
            fails++; $display("FAIL conv_timeout_status: tmo=%0d got %h want 6", tmo, d);
        end
        tests_run++;
        if (dcyc < DTO || dcyc > DTO + 2) begin
            fails++;
            $display("FAIL conv_timeout_len: got %0d busy drain cycles want %0d..%0d",
                     dcyc, DTO, DTO + 2);
        end
    endtask

    task automatic test_backpressure();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        wr(3'd1, 32'd0); model_mode = 2'b00;
        wr(3'd0, 32'd1);
        run_frame(1, 1'b0, 0, acc, outs, gerr, dcyc, tmo);
        rd(3'd6, d);
        tests_run++;
        if (tmo || gerr != 0 || acc != FP || d !== 32'(acc)) begin
            fails++;
            $display("FAIL bp_frame: tmo=%0d gate_err=%0d acc=%0d in_cnt=%0d, want 0/0/%0d/%0d",
                     tmo, gerr, acc, d, FP, FP);
        end
        rd(3'd5, d);
        tests_run++;
        if (d !== 32'h2) begin
            fails++; $display("FAIL bp_status: got %h want 2", d);
        end
    endtask

    task automatic test_cfg_lock();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        src_valid = 1'b0;
        wr(3'd0, 32'd1);
        wr(3'd1, 32'd1);
        wr(3'd2, 32'h04030201);
        tests_run++;
        if (cfg_mode !== 2'd0 || cfg_kernel !== 72'd0) begin
            fails++;
            $display("FAIL cfg_locked: mode=%h kern=%h want 0/0", cfg_mode, cfg_kernel);
        end
        run_frame(0, 1'b0, 0, acc, outs, gerr, dcyc, tmo);
        wr(3'd1, 32'd1);
        wr(3'd2, 32'h04030201);
        rd(3'd1, d);
        tests_run++;
        if (tmo || cfg_mode !== 2'd1 || cfg_kernel[31:0] !== 32'h04030201 || d !== 32'd1) begin
            fails++;
            $display("FAIL cfg_after: tmo=%0d mode=%h kern=%h rd=%h want 1/04030201/1",
                     tmo, cfg_mode, cfg_kernel, d);
        end
    endtask

    task automatic test_abort();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        wr(3'd1, 32'd0); model_mode = 2'b00;
        wr(3'd0, 32'd1);
        run_frame(0, 1'b0, 5, acc, outs, gerr, dcyc, tmo);
        src_valid = 1'b0;
        wr(3'd0, 32'd2);
        tests_run++;
        if (tmo || busy !== 1'b0 || proc_clr !== 1'b1) begin
            fails++;
            $display("FAIL abort_now: tmo=%0d busy=%b clr=%b want 0/0/1", tmo, busy, proc_clr);
        end
        @(posedge clk); #1;
        tests_run++;
        if (proc_clr !== 1'b0) begin
            fails++; $display("FAIL abort_clr_pulse: clr=%b want 0", proc_clr);
        end
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'd5) begin
            fails++; $display("FAIL abort_in_cnt: got %0d want 5", d);
        end
        wr(3'd0, 32'd3);
        @(posedge clk); #1;
        rd(3'd5, d);
        tests_run++;
        if (busy !== 1'b0 || d !== 32'h4) begin
            fails++;
            $display("FAIL start_abort_same: busy=%b status=%h want 0/4", busy, d);
        end
    endtask

    task automatic test_irq_rst();
        int acc, outs, gerr, dcyc;
        bit tmo;
        logic [31:0] d;
        wr(3'd0, 32'd5);
        run_frame(0, 1'b0, 0, acc, outs, gerr, dcyc, tmo);
        tests_run++;
        if (tmo || irq !== 1'b1) begin
            fails++; $display("FAIL irq_set: tmo=%0d irq=%b want 0/1", tmo, irq);
        end
        wr(3'd5, 32'd2);
        rd(3'd5, d);
        tests_run++;
        if (irq !== 1'b0 || d !== 32'd0) begin
            fails++; $display("FAIL irq_w1c: irq=%b status=%h want 0/0", irq, d);
        end
        wr(3'd1, 32'd2);
        wr(3'd2, 32'hA5A5A5A5);
        wr(3'd0, 32'd5);
        run_frame(0, 1'b0, 3, acc, outs, gerr, dcyc, tmo);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, irq, proc_clr, src_ready, proc_valid, cfg_mode, cfg_kernel} !== '0
            || reg_rdata !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_stream: busy=%b clr=%b sr=%b pv=%b mode=%h kern=%h, want all 0",
                     busy, proc_clr, src_ready, proc_valid, cfg_mode, cfg_kernel);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rd(3'd6, d);
        tests_run++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL rst_in_cnt: got %0d want 0", d);
        end
        rd(3'd0, d);
        tests_run++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL rst_ctrl: got %h want 0", d);
        end
    endtask

    initial begin
        rst = 1'b1;
        reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        src_valid = 1'b0; proc_ready = 1'b0;
        proc_vout = 1'b0; sink_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        test_reset();
        test_basic();
        test_conv();
        test_backpressure();
        test_cfg_lock();
        test_abort();
        test_irq_rst();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
